// File: rtl/score_drawer_pkg.sv
// score_drawer_pkg: shared state encodings, sprite geometry, screen limits and score saturation
package score_drawer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, HUND, TENS, DRAW, FLUSH, DONE} state_t;
  localparam int DIGIT_W = 16;
  localparam int DIGIT_H = 32;
  localparam int NUM_DIGITS = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [9:0] SCORE_MAX = 10'd999;
endpackage

// File: rtl/score_drawer_if.sv
// score_drawer_if: bundles start/score, loader id/i/j/colour_in and VGA x/y/colour/plot plus busy/done
interface score_drawer_if;
  logic start;
  logic [9:0] score;
  logic [4:0] id;
  logic [3:0] i;
  logic [6:0] j;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot;
  logic busy;
  logic done;
  modport master(output start, score, colour_in, input id, i, j, x, y, colour, plot, busy, done);
  modport slave(input start, score, colour_in, output id, i, j, x, y, colour, plot, busy, done);
endinterface

// File: rtl/score_drawer_bcd.sv
// bin_to_bcd3: saturating subtract-based binary to 3-digit BCD; in clock/reset/start/value, out valid/hund/tens/ones
module bin_to_bcd3
  import score_drawer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] value,
  output logic       valid,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  state_t state_q, state_d;
  logic [9:0] rem_q, rem_d;
  logic [3:0] hund_q, hund_d, tens_q, tens_d;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    hund_d = hund_q;
    tens_d = tens_q;
    case (state_q)
      IDLE: if (start) begin
        rem_d = value > SCORE_MAX ? SCORE_MAX : value;
        hund_d = 4'd0;
        tens_d = 4'd0;
        state_d = LOAD;
      end
      LOAD: state_d = HUND;
      HUND: if (rem_q >= 10'd100) begin
        rem_d = rem_q - 10'd100;
        hund_d = hund_q + 4'd1;
      end else state_d = TENS;
      TENS: if (rem_q >= 10'd10) begin
        rem_d = rem_q - 10'd10;
        tens_d = tens_q + 4'd1;
      end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      hund_q <= '0;
      tens_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
    end
  // digits stay stable after valid until the next start, so the drawer reads them directly
  assign valid = state_q == TENS && rem_q < 10'd10;
  assign hund = hund_q;
  assign tens = tens_q;
  assign ones = rem_q[3:0];
endmodule

// File: rtl/score_drawer.sv
// score_drawer: sweeps three 16x32 digit sprites through the loader (id/i/j, colour_in) and plots them via x/y/colour/plot; clock/reset plain, start/score/busy/done on bus
module score_drawer
  import score_drawer_pkg::*;
#(
  parameter logic [7:0] X0 = 8'd100,
  parameter logic [6:0] Y0 = 7'd4
) (
  input logic clock,
  input logic reset,
  score_drawer_if.slave bus
);
  state_t state_q, state_d;
  logic conv_valid;
  logic [3:0] hund, tens, ones;
  logic [1:0] d_q, d_d;
  logic [3:0] i_q, i_d, id_q, id_d;
  logic [4:0] j_q, j_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic plot_q, plot_d;
  logic row_end, last;
  bin_to_bcd3 u_bcd (
    .clock(clock),
    .reset(reset),
    .start(bus.start && state_q == IDLE),
    .value(bus.score),
    .valid(conv_valid),
    .hund(hund),
    .tens(tens),
    .ones(ones)
  );
  assign row_end = i_q == 4'(DIGIT_W - 1);
  assign last = d_q == 2'(NUM_DIGITS - 1) && row_end && j_q == 5'(DIGIT_H - 1);
  always_comb begin
    state_d = state_q;
    d_d = d_q;
    i_d = i_q;
    j_d = j_q;
    id_d = id_q;
    // coordinates travel one cycle behind the address to meet the loader's colour
    plot_d = state_q == DRAW;
    x_d = state_q == DRAW ? X0 + {2'b00, d_q, i_q} : x_q;
    y_d = state_q == DRAW ? Y0 + {2'b00, j_q} : y_q;
    case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: if (conv_valid) begin
        state_d = DRAW;
        d_d = 2'd0;
        i_d = 4'd0;
        j_d = 5'd0;
        id_d = hund;
      end
      DRAW: begin
        if (last) state_d = FLUSH;
        else begin
          i_d = i_q + 4'd1;
          j_d = row_end ? j_q + 5'd1 : j_q;
          d_d = row_end && j_q == 5'(DIGIT_H - 1) ? d_q + 2'd1 : d_q;
        end
        id_d = d_d == 2'd0 ? hund : d_d == 2'd1 ? tens : ones;
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      d_q <= '0;
      i_q <= '0;
      j_q <= '0;
      id_q <= '0;
      x_q <= '0;
      y_q <= '0;
      plot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      i_q <= i_d;
      j_q <= j_d;
      id_q <= id_d;
      x_q <= x_d;
      y_q <= y_d;
      plot_q <= plot_d;
    end
  assign bus.id = {1'b0, id_q};
  assign bus.i = i_q;
  assign bus.j = {2'b00, j_q};
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.colour = plot_q ? bus.colour_in : 3'd0;
  assign bus.plot = plot_q;
  assign bus.busy = state_q != IDLE && state_q != DONE;
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_score_drawer.sv
// tb_score_drawer: scoreboard bench for score_drawer with a 1-cycle loader model
module tb_score_drawer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int expq[$];
  score_drawer_if bus();
  score_drawer dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [2:0] model_c(input int dig, input int ii, input int jj);
    int v;
    v = dig * 3 + ii + jj * 5;
    return v[2:0];
  endfunction
  always @(posedge clock) bus.colour_in <= model_c(int'(bus.id), int'(bus.i), int'(bus.j));
  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  function automatic longint outs();
    return {bus.id, bus.i, bus.j, bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done};
  endfunction
  task automatic push_exp(input int h, input int t, input int o);
    int dig;
    for (int d = 0; d < 3; d++) begin
      dig = d == 0 ? h : d == 1 ? t : o;
      for (int jj = 0; jj < 32; jj++)
        for (int ii = 0; ii < 16; ii++)
          expq.push_back(((100 + 16 * d + ii) << 10) | ((4 + jj) << 3) | int'(model_c(dig, ii, jj)));
    end
  endtask
  initial begin
    int act, exp;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.plot) begin
          plot_cnt++;
          act = (int'(bus.x) << 10) | (int'(bus.y) << 3) | int'(bus.colour);
          if (expq.size() == 0) chk(0, "unexpected_plot", act, -1);
          else begin
            exp = expq.pop_front();
            chk(act == exp, "pixel", act, exp);
          end
        end
        if (bus.done) begin
          done_cnt++;
          chk(expq.size() == 0 && !bus.busy && !bus.plot, "done_state", expq.size(), 0);
        end
      end
    end
  end
  task automatic run(input int sc, input int h, input int t, input int o, input bit mid);
    int p0, d0, n, k, lat;
    bit pulsed;
    p0 = plot_cnt;
    d0 = done_cnt;
    n = 0;
    k = 0;
    pulsed = 0;
    lat = 2 + (h + 1) + (t + 1) + 1;
    push_exp(h, t, o);
    @(posedge clock);
    #1 bus.score = 10'(sc);
    bus.start = 1'b1;
    do begin
      @(posedge clock);
      #1 bus.start = 1'b0;
      n++;
    end while (!bus.plot && n < 200);
    chk(bus.plot && n == lat, "latency", n, lat);
    chk(bus.busy == 1'b1, "busy_drawing", bus.busy, 1);
    while (done_cnt == d0 && k < 3000) begin
      @(posedge clock);
      k++;
      if (mid && !pulsed && plot_cnt - p0 >= 300) begin
        #1 bus.start = 1'b1;
        bus.score = 10'd5;
        @(posedge clock);
        #1 bus.start = 1'b0;
        pulsed = 1;
      end
    end
    repeat (3) @(posedge clock);
    #1;
    chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
    chk(plot_cnt - p0 == 1536, "plot_count", plot_cnt - p0, 1536);
    chk(expq.size() == 0, "queue_empty", expq.size(), 0);
    chk(!bus.busy && !bus.plot, "idle_after", {bus.busy, bus.plot}, 0);
  endtask
  initial begin
    int p0, d0, k;
    bus.start = 1'b0;
    bus.score = '0;
    repeat (3) @(posedge clock);
    #1 chk(outs() == 0, "reset_outputs", outs(), 0);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk(outs() == 0, "idle_outputs", outs(), 0);
    end
    run(0, 0, 0, 0, 0);
    run(427, 4, 2, 7, 0);
    run(1023, 9, 9, 9, 0);
    run(250, 2, 5, 0, 1);
    p0 = plot_cnt;
    d0 = done_cnt;
    k = 0;
    push_exp(1, 2, 3);
    @(posedge clock);
    #1 bus.score = 10'd123;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    while (plot_cnt - p0 < 700 && k < 3000) begin
      @(negedge clock);
      #1 k++;
    end
    chk(plot_cnt - p0 == 700 && bus.plot, "reach_700", plot_cnt - p0, 700);
    reset = 1'b1;
    #1 chk(outs() == 0, "reset_mid_outputs", outs(), 0);
    expq.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1 chk(done_cnt == d0 && outs() == 0, "no_done_after_reset", done_cnt - d0, 0);
    run(58, 0, 5, 8, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/score_drawer.md
Name: score_drawer

Overview:
- Sequential drawing engine directly downstream of the score-digit sprite loader.
- On `start`, latches a binary score and converts it to three decimal digits.
- Sweeps every pixel of each 16x32 digit sprite by driving the loader's `id`/`i`/`j` inputs.
- Emits pixel-aligned `x`/`y`/`colour`/`plot` to the VGA adapter (160x120 framebuffer).
- Sits between the game-state score counter and the VGA adapter's write port.

Parameters:
- X0, 8'd100: x of the left edge of the most-significant digit.
- Y0, 7'd4: y of the top row of all digits.
- NUM_DIGITS, 3: digits drawn, fixed at 3.
- DIGIT_W, 16: sprite width in pixels; matches the 4-bit `i`.
- DIGIT_H, 32: sprite height in rows; rows 0..31 on `j`.

Ports:
- clock  in  1  system clock; only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to redraw; sampled only in IDLE.
- score  in  10  binary score; values >999 saturate to 999.
- id  out  5  digit index (0..9) to the sprite loader.
- i  out  4  sprite column to the loader.
- j  out  7  sprite row to the loader (0..31 used).
- colour_in  in  3  loader pixel colour; valid 1 cycle after `id`/`i`/`j`.
- x  out  8  VGA pixel x.
- y  out  7  VGA pixel y.
- colour  out  3  VGA pixel colour.
- plot  out  1  VGA write enable.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse after the last pixel is plotted.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-high on `reset`.
- Reset values:
  - Every output and internal register is 0; FSM = IDLE.
  - Reset asserted mid-draw aborts at once, with no partial `done`.
- FSM states: IDLE, LOAD, HUND, TENS, DRAW, FLUSH, DONE.
- IDLE:
  - `start` = 1 latches `rem` = min(`score`, 999).
  - Clears the hundreds and tens digits; goes to LOAD.
  - `start` in any other state is ignored.
- LOAD: one cycle; `busy` = 1; goes to HUND.
- HUND: if `rem` >= 100, `rem` -= 100 and hundreds++ (one subtract per cycle); else go to TENS.
- TENS:
  - Same as HUND with 10 and the tens digit.
  - On exit, ones = `rem`[3:0]. Clears digit counter d, `i`, `j`; goes to DRAW.
- DRAW (one address issued per cycle):
  - Outputs: `id` = digit[d], with d=0 hundreds, 1 tens, 2 ones.
  - `i` advances fastest 0..15; at 15 it wraps to 0 and `j`++.
  - At `j` = 31 and `i` = 15, d++ and `j` = 0.
  - After d=2, `j`=31, `i`=15 has been issued, go to FLUSH.
- Pixel pipeline (1-cycle loader latency):
  - Pixel coordinates (X0 + 16*d + `i`, Y0 + `j`) are registered alongside the address.
  - The following cycle presents `x`/`y` from that register, `colour` = `colour_in`, `plot` = 1.
  - `plot` is 1 exactly on the cycles following each DRAW cycle, including the FLUSH cycle.
- Totals:
  - 1536 `plot` pulses per redraw, contiguous, no gaps.
  - First plot at (X0, Y0); last plot at (X0+47, Y0+31).
- FLUSH: emits the last pixel; goes to DONE.
- DONE: `done` = 1 for one cycle; `busy` = 0 from this cycle; `plot` = 0; return to IDLE.
- Latency from `start` to first `plot`: 2 + (hundreds+1) + (tens+1) + 1 cycles.
- Width rules:
  - `x` arithmetic is 8-bit; the parameters guarantee no overflow (X0+47 <= 159).
  - `y` is 7-bit (Y0+31 <= 119).
  - `id` is zero-extended from the 4-bit digit.
- Outputs while not in DRAW/FLUSH: `id`, `i`, `j` hold their last value; `plot` = 0.
- All colours, including black (0), are plotted; no transparency.

Decomposition:
- Shared package holds:
  - State encodings (3-bit).
  - DIGIT_W, DIGIT_H, and the screen limits 160/120.
  - The saturation constant 999.
- One natural sub-module: `bin_to_bcd3`, the sequential subtract-based converter (states LOAD/HUND/TENS with start/valid handshake).
- The sweep and pixel pipeline stay in `score_drawer`.

Test Plan:
1. Reset then idle, `start`=0 for 20 cycles -> all outputs 0, no `plot`.
2. `score`=0, `start` pulse -> `id`=0 throughout; exactly 1536 `plot` pulses; first (x,y)=(100,4); last (147,35); one `done` pulse.
3. `score`=427 with a loader model returning `colour_in` = (address-derived) -> `id` sequence 4,2,7; first digit-1 plot at x=116,y=4; each plotted `colour` matches the model for that x,y (checks 1-cycle alignment).
4. `score`=1023 -> saturates; `id`=9 for all digits; 1536 plots.
5. `start` re-pulsed mid-DRAW -> ignored; plot count still 1536; single `done`.
6. `reset` asserted at the 700th plot -> outputs 0 same cycle; no `done`; a new `start` afterwards completes normally.
